muxn_skid_pipe: RTL and testbench
=================================

Name: muxn_skid_pipe

Overview:
- Parametrised N-input, WIDTH-bit registered selector for the issue/operand datapath of the four-issue pipeline.
- Generalises the fixed 11-way combinational select. Input count and width are parameters.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates a selection.
- Adds an out-of-range select flag and a synchronous flush for pipeline squash.

Parameters:
- WIDTH, 32, data width of each input and of y.
- N, 11, number of data inputs (legal range 2..16).
- SELW, $clog2(N), select width (derived; do not override).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- d  input  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- s  input  SELW  select index.
- in_valid  input  1  producer offers d/s this cycle.
- in_ready  output  1  block can accept this cycle.
- y  output  WIDTH  selected data, registered.
- sel_err  output  1  set when the entry in y was captured with s >= N.
- out_valid  output  1  y/sel_err hold a valid entry.
- out_ready  input  1  consumer takes y this cycle.

Behaviour:
- Storage: main register M (drives y, sel_err, out_valid) and skid register K (k_valid, k_data, k_err).
- Select function: sel = (s < N) ? d[s] : 0; err = (s >= N). Purely combinational; captured only on accept.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !k_valid. It is combinational from state only, with no path from in_valid or out_ready.
- Latency: an entry accepted in cycle t appears on y with out_valid=1 in cycle t+1 when M is empty or draining.
- Update rules when not reset and not flush:
  - M empty or drain, K empty: accept loads M from the select function. No accept clears out_valid.
  - M empty or drain, K full: K moves to M and K empties. in_ready was 0, so no accept is possible.
  - M full, no drain: accept loads K. M holds unchanged.
- y and sel_err change only when M loads. When out_valid=0 they hold their last value.
- Ordering is strict FIFO: entries leave in acceptance order, each exactly once.
- Skid buffer gives full throughput: one accept and one drain per cycle is sustained indefinitely with in_ready=1.
- flush: clears out_valid and k_valid next cycle.
  - An accept in the flush cycle is discarded; flush wins.
  - y and sel_err hold their values.
- reset: out_valid=0, k_valid=0, y=0, sel_err=0, k_data=0, k_err=0.
  - in_ready=1 during and after reset.
  - Reset mid-transfer discards all entries.
  - reset has priority over flush.
- Assertion (bench): when out_valid=1 and out_ready=0, y, sel_err and out_valid stay stable until a drain.

Test Plan:
- Single transfer. Reset, then N=11, WIDTH=32, d[k]=32'h100+k, s=4'd7, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, y=32'h107, sel_err=0; following cycle out_valid=0.
- Out-of-range select. s=4'd10 -> y=32'h10A, sel_err=0. s=4'd11 -> y=0, sel_err=1. s=4'd15 -> y=0, sel_err=1.
- Back-pressure. Stream s=0,1,2,3 back-to-back with out_ready=0.
  - Cycle after 1st accept: out_valid=1, y=32'h100.
  - After 2nd accept: in_ready=0. Inputs 2,3 are held by the producer.
  - Raise out_ready -> y sequence 100,101,102,103, no loss or duplicate.
- Full throughput. in_valid=1, out_ready=1 for 20 cycles, s cycling 0..10 -> in_ready constantly 1; y matches stimulus delayed 1 cycle every cycle.
- Flush. Fill M and K (out_ready=0, two accepts), then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears on y.
- Reset mid-operation. With M and K full, assert reset for 1 cycle -> out_valid=0, y=0, sel_err=0, in_ready=1. Repeat the stimulus with N=4, WIDTH=8 (SELW=2; s=3 legal, no error encoding reachable).

Source files
------------

// File: rtl/muxn_skid_pipe.sv
// -----------------------------------------------------------------------------
// muxn_skid_pipe
//
// Parametrised N-input, WIDTH-bit selector whose result is registered behind a
// valid/ready handshake. A two-entry skid arrangement (main register M plus
// skid register K) lets the producer see a purely registered in_ready while
// still sustaining one transfer per cycle under continuous flow.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears all held entries and y/sel_err
//   flush      synchronous squash; drops held entries, y/sel_err keep value
//   d          packed data inputs, input k at bits [k*WIDTH +: WIDTH]
//   s          select index
//   in_valid   producer offers d/s this cycle
//   in_ready   block can accept this cycle (depends on state only)
//   y          selected data of the entry in M (registered)
//   sel_err    entry in M was captured with s >= N
//   out_valid  M holds a valid entry
//   out_ready  consumer takes y this cycle
// -----------------------------------------------------------------------------
module muxn_skid_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 11,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  // Unpacked view of the data inputs.
  logic [WIDTH-1:0] din [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign din[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Combinational select; an index past the last input yields zero data and
  // raises the error flag that travels with the entry.
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) begin
        sel_data = din[k];
      end
    end
  end

  assign sel_bad = ({1'b0, s} >= (SELW+1)'(N));

  // Main register M drives the outputs; K catches the one entry that may
  // arrive while M is stalled, since in_ready is a cycle late to drop.
  logic             m_valid_reg;
  logic [WIDTH-1:0] m_data_reg;
  logic             m_err_reg;
  logic             k_valid_reg;
  logic [WIDTH-1:0] k_data_reg;
  logic             k_err_reg;

  logic accept;
  logic drain;
  logic m_free;

  // Ready only while the skid slot is empty: a registered signal, so there is
  // no combinational path from in_valid or out_ready.
  assign in_ready = !k_valid_reg;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid_reg && out_ready;
  assign m_free   = !m_valid_reg || drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_err_reg   <= 1'b0;
      k_valid_reg <= 1'b0;
      k_data_reg  <= '0;
      k_err_reg   <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits are squashed,
      // which also discards any accept presented in this cycle.
      m_valid_reg <= 1'b0;
      k_valid_reg <= 1'b0;
    end else if (m_free) begin
      if (k_valid_reg) begin
        // Older entry in K goes first to preserve acceptance order.
        m_valid_reg <= 1'b1;
        m_data_reg  <= k_data_reg;
        m_err_reg   <= k_err_reg;
        k_valid_reg <= 1'b0;
      end else if (accept) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= sel_data;
        m_err_reg   <= sel_bad;
      end else begin
        m_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // M stalled: park the new entry in K.
      k_valid_reg <= 1'b1;
      k_data_reg  <= sel_data;
      k_err_reg   <= sel_bad;
    end
  end

  assign y         = m_data_reg;
  assign sel_err   = m_err_reg;
  assign out_valid = m_valid_reg;

endmodule

// File: tb/tb_muxn_skid_pipe.sv
// -----------------------------------------------------------------------------
// tb_muxn_skid_pipe
//
// Two instances (N=11/WIDTH=32 and N=4/WIDTH=8) share the same handshake and
// control stimulus; their data buses are derived from one table of values.
// The reference model is a FIFO of expected {err,data} per instance: entries
// are pushed on accept, dropped on flush/reset, and popped by a monitor on
// every drain. Occupancy rules (in_ready, out_valid) are derived from the
// queue size.
// -----------------------------------------------------------------------------
module tb_muxn_skid_pipe;

  localparam int WA = 32;
  localparam int NA = 11;
  localparam int SA = $clog2(NA);
  localparam int WB = 8;
  localparam int NB = 4;
  localparam int SB = $clog2(NB);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [3:0]     s_in = '0;
  logic [31:0]    dv [NA];

  logic [NA*WA-1:0] d_a;
  logic [NB*WB-1:0] d_b;
  logic [SA-1:0]    s_a;
  logic [SB-1:0]    s_b;

  logic          in_ready_a, sel_err_a, out_valid_a;
  logic [WA-1:0] y_a;
  logic          in_ready_b, sel_err_b, out_valid_b;
  logic [WB-1:0] y_b;

  always #5 clk = ~clk;

  always_comb begin
    d_a = '0;
    d_b = '0;
    for (int k = 0; k < NA; k++) d_a[k*WA +: WA] = dv[k];
    for (int k = 0; k < NB; k++) d_b[k*WB +: WB] = dv[k][WB-1:0];
  end
  assign s_a = s_in;
  assign s_b = s_in[SB-1:0];

  muxn_skid_pipe #(.WIDTH(WA), .N(NA)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .d(d_a), .s(s_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .y(y_a), .sel_err(sel_err_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  muxn_skid_pipe #(.WIDTH(WB), .N(NB)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .d(d_b), .s(s_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .y(y_b), .sel_err(sel_err_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues: {err, data}.
  logic [WA:0] qa [$];
  logic [WB:0] qb [$];

  logic        armed = 1'b0;
  logic        hs_last = 1'b0;
  logic        prev_reset = 1'b0, prev_flush = 1'b0, prev_stall = 1'b0;
  logic [WA-1:0] prev_ya = '0;
  logic [WB-1:0] prev_yb = '0;
  logic        prev_erra = 1'b0;

  // Monitor/model: runs on the falling edge, where inputs and outputs are
  // stable, and predicts the effect of the coming rising edge.
  always @(negedge clk) begin
    logic [WA:0] ea;
    logic [WB:0] eb;
    int          sa_i;
    int          sb_i;
    if (armed) begin
      chk("out_valid_a", 64'(out_valid_a), 64'(qa.size() != 0));
      chk("in_ready_a",  64'(in_ready_a),  64'(qa.size() < 2));
      chk("out_valid_b", 64'(out_valid_b), 64'(qb.size() != 0));
      chk("in_ready_b",  64'(in_ready_b),  64'(qb.size() < 2));
      if (prev_reset) begin
        chk("reset_y_a", 64'(y_a), 64'd0);
        chk("reset_err_a", 64'(sel_err_a), 64'd0);
        chk("reset_y_b", 64'(y_b), 64'd0);
      end else if (!out_valid_a) begin
        chk("hold_y_a", 64'(y_a), 64'(prev_ya));
        chk("hold_err_a", 64'(sel_err_a), 64'(prev_erra));
        chk("hold_y_b", 64'(y_b), 64'(prev_yb));
      end
      if (prev_stall && !prev_reset && !prev_flush) begin
        chk("stall_valid_a", 64'(out_valid_a), 64'd1);
        chk("stall_y_a", 64'(y_a), 64'(prev_ya));
        chk("stall_err_a", 64'(sel_err_a), 64'(prev_erra));
      end
      if (out_valid_a && out_ready && !reset && qa.size() != 0) begin
        ea = qa.pop_front();
        chk("drain_y_a", 64'(y_a), 64'(ea[WA-1:0]));
        chk("drain_err_a", 64'(sel_err_a), 64'(ea[WA]));
        $display("xfer a: y=%08h sel_err=%0b", y_a, sel_err_a);
      end
      if (out_valid_b && out_ready && !reset && qb.size() != 0) begin
        eb = qb.pop_front();
        chk("drain_y_b", 64'(y_b), 64'(eb[WB-1:0]));
        chk("drain_err_b", 64'(sel_err_b), 64'(eb[WB]));
        $display("xfer b: y=%02h sel_err=%0b", y_b, sel_err_b);
      end
    end
    hs_last = in_valid && in_ready_a;
    if (reset || flush) begin
      qa.delete();
      qb.delete();
    end else if (in_valid && in_ready_a) begin
      sa_i = int'(s_in);
      sb_i = sa_i % NB;
      ea = (sa_i < NA) ? {1'b0, dv[sa_i]} : {1'b1, 32'd0};
      eb = {1'b0, dv[sb_i][WB-1:0]};
      qa.push_back(ea);
      qb.push_back(eb);
    end
    if (reset) armed = 1'b1;
    prev_reset = reset;
    prev_flush = flush;
    prev_stall = out_valid_a && !out_ready;
    prev_ya    = y_a;
    prev_erra  = sel_err_a;
    prev_yb    = y_b;
  end

  // Offer one entry and hold it until the handshake completes.
  task automatic send(input logic [3:0] sv, output int waits);
    in_valid = 1'b1;
    s_in     = sv;
    waits    = 0;
    forever begin
      @(posedge clk);
      if (hs_last) break;
      waits++;
      if (waits > 40) begin
        chk("send_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    for (int k = 0; k < NA; k++) dv[k] = 32'h100 + k;
    idle(3);
    reset = 1'b0;
    idle(1);

    // Single transfer and select range.
    out_ready = 1'b1;
    send(4'd7, w);
    chk("single_valid", 64'(out_valid_a), 64'd1);
    chk("single_y", 64'(y_a), 64'h107);
    chk("single_err", 64'(sel_err_a), 64'd0);
    idle(1);
    chk("single_after", 64'(out_valid_a), 64'd0);
    send(4'd10, w);
    chk("s10_y", 64'(y_a), 64'h10A);
    chk("s10_err", 64'(sel_err_a), 64'd0);
    send(4'd11, w);
    chk("s11_y", 64'(y_a), 64'd0);
    chk("s11_err", 64'(sel_err_a), 64'd1);
    send(4'd15, w);
    chk("s15_y", 64'(y_a), 64'd0);
    chk("s15_err", 64'(sel_err_a), 64'd1);
    idle(2);

    // Back-pressure: two accepts fill M and K, the third is held.
    out_ready = 1'b0;
    send(4'd0, w);
    chk("bp_first_y", 64'(y_a), 64'h100);
    send(4'd1, w);
    chk("bp_full_ready", 64'(in_ready_a), 64'd0);
    in_valid = 1'b1;
    s_in     = 4'd2;
    idle(3);
    out_ready = 1'b1;
    send(4'd2, w);
    send(4'd3, w);
    idle(4);

    // Full throughput: every offer must be taken without waiting.
    for (int i = 0; i < 20; i++) begin
      send(4'(i % 11), w);
      chk("throughput_wait", 64'(w), 64'd0);
    end
    idle(3);

    // Flush with a concurrent offer.
    out_ready = 1'b0;
    send(4'd1, w);
    send(4'd2, w);
    in_valid = 1'b1;
    s_in     = 4'd5;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid_a), 64'd0);
    chk("flush_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    idle(3);

    // Reset with M and K full.
    out_ready = 1'b0;
    send(4'd3, w);
    send(4'd4, w);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_valid_a", 64'(out_valid_a), 64'd0);
    chk("rst_y_a", 64'(y_a), 64'd0);
    chk("rst_err_a", 64'(sel_err_a), 64'd0);
    chk("rst_ready_a", 64'(in_ready_a), 64'd1);
    chk("rst_valid_b", 64'(out_valid_b), 64'd0);
    chk("rst_y_b", 64'(y_b), 64'd0);
    chk("rst_ready_b", 64'(in_ready_b), 64'd1);
    out_ready = 1'b1;
    idle(2);

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !hs_last)) begin
        in_valid = ($urandom % 4) != 0;
        s_in     = 4'($urandom % 16);
        for (int k = 0; k < NA; k++) dv[k] = $urandom;
      end
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
      reset     = ($urandom % 200) == 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("final_empty_a", 64'(qa.size()), 64'd0);
    chk("final_empty_b", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
